// File: rtl/nmr_sched_pkg.sv
// ---------------------------------------------------------------------------
// nmr_sched_pkg
// Shared definitions for the NMR scan scheduler: one-hot state encoding and
// default widths / ack timeout used by nmr_bstrm_scan_sched.
// ---------------------------------------------------------------------------
package nmr_sched_pkg;

   localparam int SCAN_WIDTH_DEF = 16;  // scan count / counter width
   localparam int DLY_WIDTH_DEF  = 32;  // TR delay counter width (CLK cycles)
   localparam int ACK_TO_DEF     = 15;  // cycles allowed for BSTRM_DONE to fall

   // One-hot encoding: each state owns one flop bit.
   typedef enum logic [8:0] {
      ST_IDLE     = 9'b0_0000_0001,
      ST_CHK      = 9'b0_0000_0010,
      ST_WAIT_RDY = 9'b0_0000_0100,
      ST_PULSE    = 9'b0_0000_1000,
      ST_WAIT_ACK = 9'b0_0001_0000,
      ST_RUN      = 9'b0_0010_0000,
      ST_DELAY    = 9'b0_0100_0000,
      ST_DRAIN    = 9'b0_1000_0000,
      ST_FINISH   = 9'b1_0000_0000
   } sched_state_e;

endpackage

// File: rtl/nmr_dly_cnt.sv
// ---------------------------------------------------------------------------
// nmr_dly_cnt
// Loadable down-counter that stops at zero. Used by the scan scheduler for
// the TR repetition delay and for the start-acknowledge timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : load value_i (has priority over en_i)
//   value_i    : value to load
//   en_i       : decrement by one when non-zero
//   zero_o     : count is 0
//   one_o      : count is 1 (last cycle before expiry)
// ---------------------------------------------------------------------------
module nmr_dly_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             en_i,
   output logic             zero_o,
   output logic             one_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update
   // together from values computed in the previous cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/nmr_bstrm_scan_sched.sv
// ---------------------------------------------------------------------------
// nmr_bstrm_scan_sched
// Runs the stored pulse program NUM_SCANS times through the bitstream
// controller's START/DONE handshake, with TR_DLY idle cycles between the
// DONE rise of one scan and the START of the next.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   GO           : one-cycle run request (accepted in IDLE with ABORT low)
//   ABORT        : stop scheduling further scans
//   NUM_SCANS    : scans per run (latched on GO)
//   TR_DLY       : repetition delay in cycles (latched on GO)
//   BSTRM_START  : one-cycle start pulse to the bitstream controller
//   BSTRM_DONE   : controller idle flag
//   BUSY         : run in progress
//   DONE         : one-cycle end-of-run pulse
//   SCAN_TICK    : one-cycle pulse per completed scan
//   SCAN_CNT     : completed scans in the current run (saturating)
//   ABORTED, ERR : sticky abort / ack-timeout status, cleared on GO
// ---------------------------------------------------------------------------
module nmr_bstrm_scan_sched
   import nmr_sched_pkg::*;
#(
   parameter int SCAN_WIDTH = SCAN_WIDTH_DEF,
   parameter int DLY_WIDTH  = DLY_WIDTH_DEF,
   parameter int ACK_TO     = ACK_TO_DEF
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  GO,
   input  logic                  ABORT,
   input  logic [SCAN_WIDTH-1:0] NUM_SCANS,
   input  logic [DLY_WIDTH-1:0]  TR_DLY,
   output logic                  BSTRM_START,
   input  logic                  BSTRM_DONE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  SCAN_TICK,
   output logic [SCAN_WIDTH-1:0] SCAN_CNT,
   output logic                  ABORTED,
   output logic                  ERR
);

   localparam int ACK_W = $clog2(ACK_TO + 1);

   sched_state_e          state_q, state_d;
   logic [SCAN_WIDTH-1:0] num_q, num_d;
   logic [DLY_WIDTH-1:0]  tr_q, tr_d;
   logic [SCAN_WIDTH-1:0] cnt_q, cnt_d;
   logic                  tick_q, tick_d;
   logic                  aborted_q, aborted_d;
   logic                  err_q, err_d;

   logic dly_load, dly_en, dly_zero, dly_one;
   logic ack_load, ack_en, ack_zero, ack_one;

   // One extra bit so the all-ones case neither wraps nor matches NUM_SCANS.
   logic [SCAN_WIDTH:0]   cnt_inc;
   logic [SCAN_WIDTH-1:0] cnt_sat;
   logic                  last_scan;

   assign cnt_inc   = {1'b0, cnt_q} + {{SCAN_WIDTH{1'b0}}, 1'b1};
   assign cnt_sat   = cnt_inc[SCAN_WIDTH] ? cnt_q : cnt_inc[SCAN_WIDTH-1:0];
   assign last_scan = (cnt_inc == {1'b0, num_q});

   // TR delay: loaded on the DONE-rise cycle, expires TR_DLY cycles later.
   nmr_dly_cnt #(.WIDTH(DLY_WIDTH)) u_dly_cnt (
      .clk     (CLK),
      .rst_n   (RST_N),
      .load_i  (dly_load),
      .value_i (tr_q),
      .en_i    (dly_en),
      .zero_o  (dly_zero),
      .one_o   (dly_one)
   );

   // Ack timeout: loaded in PULSE, the ACK_TO-th WAIT_ACK cycle sees one_o.
   nmr_dly_cnt #(.WIDTH(ACK_W)) u_ack_cnt (
      .clk     (CLK),
      .rst_n   (RST_N),
      .load_i  (ack_load),
      .value_i (ACK_W'(ACK_TO)),
      .en_i    (ack_en),
      .zero_o  (ack_zero),
      .one_o   (ack_one)
   );

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      tr_d      = tr_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      aborted_d = aborted_q;
      err_d     = err_q;
      dly_load  = 1'b0;
      dly_en    = 1'b0;
      ack_load  = 1'b0;
      ack_en    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (GO && !ABORT) begin
               num_d     = NUM_SCANS;
               tr_d      = TR_DLY;
               cnt_d     = '0;
               aborted_d = 1'b0;
               err_d     = 1'b0;
               state_d   = ST_CHK;
            end
         end
         ST_CHK: begin
            if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_FINISH;
            end else if (num_q == '0) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_FINISH;
            end else if (BSTRM_DONE) begin
               state_d = ST_PULSE;
            end
         end
         ST_PULSE: begin
            // START is already on the wire this cycle, so an abort must
            // still let that sequence drain.
            ack_load = 1'b1;
            if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_DRAIN;
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            ack_en = 1'b1;
            if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (!BSTRM_DONE) begin
               state_d = ST_RUN;
            end else if (ack_one || ack_zero) begin
               err_d   = 1'b1;
               state_d = ST_FINISH;
            end
         end
         ST_RUN: begin
            if (BSTRM_DONE) begin
               cnt_d  = cnt_sat;
               tick_d = 1'b1;
               if (ABORT) begin
                  aborted_d = 1'b1;
               end
               if (last_scan) begin
                  state_d = ST_FINISH;
               end else if (ABORT) begin
                  state_d = ST_DRAIN;
               end else if (tr_q == '0) begin
                  state_d = ST_PULSE;
               end else begin
                  dly_load = 1'b1;
                  state_d  = ST_DELAY;
               end
            end else if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_DRAIN;
            end
         end
         ST_DELAY: begin
            dly_en = 1'b1;
            if (ABORT) begin
               aborted_d = 1'b1;
               state_d   = ST_FINISH;
            end else if (dly_one || dly_zero) begin
               state_d = ST_PULSE;
            end
         end
         ST_DRAIN: begin
            if (BSTRM_DONE) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: the latched configuration is reset along with the control state;
   // these are plain registers, not a memory array, so resetting them is free
   // and keeps every output defined straight out of reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         tr_q      <= '0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         tr_q      <= tr_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
      end
   end

   // Moore outputs decoded straight from the state flops.
   assign BSTRM_START = (state_q == ST_PULSE);
   assign DONE        = (state_q == ST_FINISH);
   assign BUSY        = (state_q != ST_IDLE);
   assign SCAN_TICK   = tick_q;
   assign SCAN_CNT    = cnt_q;
   assign ABORTED     = aborted_q;
   assign ERR         = err_q;

endmodule
